// File: rtl/fetch_unit_r32i.sv
// Instruction fetch stage: owns the PC, drives the instruction cache address and
// holds one registered instruction for decode, with redirect, miss and hold handling.
module fetch_unit_r32i #(
    parameter int unsigned      dataW    = 32,
    parameter logic [dataW-1:0] ResetVec = '0
) (
    input  logic             clock,
    input  logic             reset,
    output logic [dataW-1:0] ProgAddr,
    input  logic             InsCacheStall,
    input  logic [dataW-1:0] CacheIns,
    input  logic             BranchTaken,
    input  logic [dataW-1:0] BranchTarget,
    input  logic             DecodeStall,
    output logic [dataW-1:0] FetchIns,
    output logic [dataW-1:0] FetchPC,
    output logic             FetchValid,
    output logic             MisalignErr,
    output logic [15:0]      MissCycles
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        MISS,
        HOLD,
        HALT
    } fetchState_e;

    typedef enum logic [2:0] {
        EvNone,
        EvRedirect,
        EvMisalign,
        EvHold,
        EvRelease,
        EvMiss,
        EvIssue
    } fetchEvent_e;

    fetchState_e      state;
    fetchEvent_e      evt;
    logic [dataW-1:0] pcReg;

    function automatic logic [dataW-1:0] nextPc(input logic [dataW-1:0] pc);
        // Natural truncation gives the wrap from the top word back to zero.
        return pc + dataW'(32'd4);
    endfunction

    function automatic logic [15:0] satInc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end
        return v + 16'd1;
    endfunction

    // One event per cycle, already resolved in priority order:
    // redirect > decode hold > cache stall > issue.
    always_comb begin
        evt = EvNone;
        case (state)
            FETCH, MISS, HOLD: begin
                if (BranchTaken) begin
                    if (BranchTarget[1:0] == 2'b00) begin
                        evt = EvRedirect;
                    end else begin
                        evt = EvMisalign;
                    end
                end else if (state == HOLD) begin
                    if (DecodeStall) begin
                        evt = EvHold;
                    end else begin
                        evt = EvRelease;
                    end
                end else if (FetchValid && DecodeStall) begin
                    evt = EvHold;
                end else if (InsCacheStall) begin
                    evt = EvMiss;
                end else begin
                    evt = EvIssue;
                end
            end
            default: evt = EvNone;
        endcase
    end

    // Fetch register stage: PC, held instruction and status all update here.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pcReg       <= ResetVec;
            FetchIns    <= '0;
            FetchPC     <= '0;
            FetchValid  <= 1'b0;
            MisalignErr <= 1'b0;
            MissCycles  <= '0;
            state       <= IDLE;
        end else begin
            if (state == MISS) begin
                MissCycles <= satInc16(MissCycles);
            end
            case (evt)
                EvRedirect: begin
                    pcReg      <= BranchTarget;
                    FetchValid <= 1'b0;
                    state      <= FETCH;
                end
                EvMisalign: begin
                    MisalignErr <= 1'b1;
                    FetchValid  <= 1'b0;
                    state       <= HALT;
                end
                EvHold: begin
                    state <= HOLD;
                end
                EvRelease: begin
                    // Decode took the held instruction this cycle.
                    FetchValid <= 1'b0;
                    state      <= FETCH;
                end
                EvMiss: begin
                    // Only reached when nothing is held for decode.
                    FetchValid <= 1'b0;
                    state      <= MISS;
                end
                EvIssue: begin
                    FetchIns   <= CacheIns;
                    FetchPC    <= pcReg;
                    FetchValid <= 1'b1;
                    pcReg      <= nextPc(pcReg);
                    state      <= FETCH;
                end
                default: begin
                    if (state == IDLE) begin
                        state <= FETCH;
                    end
                end
            endcase
        end
    end

    assign ProgAddr = pcReg;

endmodule
